arth_scheduler: RTL and testbench



---
 rtl/arth_scheduler_pkg.sv | 34 +++
 rtl/arth_scheduler_rr_arb2.sv | 48 ++++
 rtl/arth_scheduler.sv | 143 ++++++++++++++
 tb/tb_arth_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arth_scheduler_pkg.sv
// Shared types and helpers for arth_scheduler: FSM state encoding, opcode
// constants and per-opcode latency selection.
package arth_scheduler_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_0 = 2'b00;
    localparam logic [1:0] OP_1 = 2'b01;
    localparam logic [1:0] OP_2 = 2'b10;
    localparam logic [1:0] OP_3 = 2'b11;

    function automatic logic [CNT_W-1:0] lat_sel(
        input logic [1:0]       opcode,
        input logic [CNT_W-1:0] lat0,
        input logic [CNT_W-1:0] lat1,
        input logic [CNT_W-1:0] lat2,
        input logic [CNT_W-1:0] lat3
    );
        case (opcode)
            OP_0:    lat_sel = lat0;
            OP_1:    lat_sel = lat1;
            OP_2:    lat_sel = lat2;
            default: lat_sel = lat3;
        endcase
    endfunction

endpackage

// File: rtl/arth_scheduler_rr_arb2.sv
// Two-input grant for arth_scheduler. Round-robin with a last-served register by
// default; ARTH_SCHED_FIXED_PRIO_EN selects fixed priority (port 0 wins ties).
module rr_arb2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] gnt
);

`ifdef ARTH_SCHED_FIXED_PRIO_EN

    logic unused_ok;
    assign unused_ok = ^{clock, reset, upd, upd_id};

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end

`else

    // Reset to 1 so that port 0 wins the first tie.
    logic last_served;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_served <= 1'b1;
        end else if (upd) begin
            last_served <= upd_id;
        end
    end

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_served ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

`endif

endmodule

// File: rtl/arth_scheduler.sv
// Shares one Arth_module between two valid/ready requesters, one op in flight.
// Build option: ARTH_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration.
module arth_scheduler
    import arth_scheduler_pkg::*;
#(
    parameter int               WIDTH   = 17,
    parameter logic [CNT_W-1:0] LAT_OP0 = 5'd2,
    parameter logic [CNT_W-1:0] LAT_OP1 = 5'd18,
    parameter logic [CNT_W-1:0] LAT_OP2 = 5'd18,
    parameter logic [CNT_W-1:0] LAT_OP3 = 5'd2
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_V1,
    input  logic [WIDTH-1:0] req0_V2,
    input  logic [1:0]       req0_opcode,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_V1,
    input  logic [WIDTH-1:0] req1_V2,
    input  logic [1:0]       req1_opcode,

    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_answer,
    output logic             resp_ovw,

    output logic [WIDTH-1:0] arth_V1,
    output logic [WIDTH-1:0] arth_V2,
    output logic [1:0]       arth_opcode,
    output logic             arth_newop,
    input  logic [WIDTH-1:0] arth_answer,
    input  logic             arth_ovw
);

    state_t           state;
    state_t           state_nx;
    logic             owner;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       gnt;
    logic             accept;
    logic             resp_fire;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .req    ({req1_valid, req0_valid}),
        .upd    (resp_fire),
        .upd_id (owner),
        .gnt    (gnt)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        arth_newop  = 1'b0;
        resp_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                // Ready is masked during reset so a held request is never acknowledged.
                req0_ready = gnt[0] & ~reset;
                req1_ready = gnt[1] & ~reset;
                if (req0_ready || req1_ready) begin
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                arth_newop = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                resp0_valid = ~owner;
                resp1_valid = owner;
                resp_fire   = owner ? resp1_ready : resp0_ready;
                if (resp_fire) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign accept = req0_ready | req1_ready;

    // Operand registers drive the Arth_module directly and are only written on
    // accept, so they hold their value through WAIT/RESP and back in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner       <= 1'b0;
            arth_V1     <= '0;
            arth_V2     <= '0;
            arth_opcode <= OP_0;
            cnt         <= '0;
            resp_answer <= '0;
            resp_ovw    <= 1'b0;
        end else begin
            if (accept) begin
                owner       <= req1_ready;
                arth_V1     <= req1_ready ? req1_V1     : req0_V1;
                arth_V2     <= req1_ready ? req1_V2     : req0_V2;
                arth_opcode <= req1_ready ? req1_opcode : req0_opcode;
            end

            if (state == S_ISSUE) begin
                cnt <= lat_sel(arth_opcode, LAT_OP0, LAT_OP1, LAT_OP2, LAT_OP3) - 5'd1;
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - 5'd1;
            end

            if (state == S_WAIT && cnt == '0) begin
                resp_answer <= arth_answer;
                resp_ovw    <= arth_ovw;
            end
        end
    end

endmodule

// File: tb/tb_arth_scheduler.sv
// Self-checking bench for arth_scheduler: behavioural Arth_module model with
// exact-latency answers, expected-result queue, and directed scenarios.
module tb_arth_scheduler;

    localparam logic [1:0] OP0 = 2'b00;
    localparam logic [1:0] OP1 = 2'b01;
    localparam logic [1:0] OP2 = 2'b10;
    localparam logic [1:0] OP3 = 2'b11;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [16:0] req0_V1, req0_V2, req1_V1, req1_V2;
    logic [1:0]  req0_opcode, req1_opcode;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [16:0] resp_answer;
    logic        resp_ovw;
    logic [16:0] arth_V1, arth_V2, arth_answer;
    logic [1:0]  arth_opcode;
    logic        arth_newop, arth_ovw;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int since = 0;

    typedef struct {
        int          port;
        logic [16:0] ans;
        logic        ovw;
    } exp_t;
    exp_t sb[$];

    arth_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_V1     (req0_V1),
        .req0_V2     (req0_V2),
        .req0_opcode (req0_opcode),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_V1     (req1_V1),
        .req1_V2     (req1_V2),
        .req1_opcode (req1_opcode),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_answer (resp_answer),
        .resp_ovw    (resp_ovw),
        .arth_V1     (arth_V1),
        .arth_V2     (arth_V2),
        .arth_opcode (arth_opcode),
        .arth_newop  (arth_newop),
        .arth_answer (arth_answer),
        .arth_ovw    (arth_ovw)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return 2;
            2'b01:   return 18;
            2'b10:   return 18;
            default: return 2;
        endcase
    endfunction

    function automatic logic [16:0] f_ans(input logic [16:0] a, input logic [16:0] b, input logic [1:0] op);
        return (a ^ {b[15:0], b[16]}) + {15'd0, op};
    endfunction

    function automatic logic f_ovw(input logic [16:0] a, input logic [16:0] b, input logic [1:0] op);
        return a[16] ^ b[0] ^ op[0];
    endfunction

    // Arth_module model: answer is correct only on the exact cycle its latency allows.
    always @(posedge clock) begin
        if (reset)                        since <= 0;
        else if (arth_newop)              since <= 1;
        else if (since != 0 && since < 63) since <= since + 1;
    end

    always_comb begin
        if (since == lat_of(arth_opcode)) begin
            arth_answer = f_ans(arth_V1, arth_V2, arth_opcode);
            arth_ovw    = f_ovw(arth_V1, arth_V2, arth_opcode);
        end else begin
            arth_answer = 17'h15555;
            arth_ovw    = ~f_ovw(arth_V1, arth_V2, arth_opcode);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on every response handshake.
    always @(negedge clock) begin
        if (!reset) begin
            for (int p = 0; p < 2; p++) begin
                logic v, r;
                v = (p == 0) ? resp0_valid : resp1_valid;
                r = (p == 0) ? resp0_ready : resp1_ready;
                if (v && r) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("resp_port",   32'(p),           32'(e.port));
                        check("resp_answer", 32'(resp_answer), 32'(e.ans));
                        check("resp_ovw",    32'(resp_ovw),    32'(e.ovw));
                    end
                end
            end
        end
    end

    task automatic push_exp(input int port);
        exp_t e;
        e.port = port;
        if (port == 0) begin
            e.ans = f_ans(req0_V1, req0_V2, req0_opcode);
            e.ovw = f_ovw(req0_V1, req0_V2, req0_opcode);
        end else begin
            e.ans = f_ans(req1_V1, req1_V2, req1_opcode);
            e.ovw = f_ovw(req1_V1, req1_V2, req1_opcode);
        end
        sb.push_back(e);
    endtask

    // Called at posedge+1 with reqN_valid already high; returns at posedge+1 after the accept edge.
    task automatic wait_accept(input int port, output int rcyc);
        bit got;
        got  = 0;
        rcyc = -1;
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if ((port == 0) ? req0_ready : req1_ready) begin
                got  = 1;
                rcyc = cyc;
                push_exp(port);
            end
            @(posedge clock);
            #1;
        end
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
        check("accept_seen", 32'(got), 32'd1);
        if (got) check("newop_after_accept", 32'(arth_newop), 32'd1);
    endtask

    task automatic issue(input int port, input logic [16:0] v1, input logic [16:0] v2,
                         input logic [1:0] op, output int rcyc);
        if (port == 0) begin
            req0_V1 = v1; req0_V2 = v2; req0_opcode = op; req0_valid = 1'b1;
        end else begin
            req1_V1 = v1; req1_V2 = v2; req1_opcode = op; req1_valid = 1'b1;
        end
        wait_accept(port, rcyc);
    endtask

    // Result must appear LAT+2 cycles after the cycle in which ready was seen.
    task automatic wait_resp(input int port, input int rcyc, input int lat);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if ((port == 0) ? resp0_valid : resp1_valid) got = 1;
            else begin
                @(posedge clock);
                #1;
            end
        end
        check("resp_seen", 32'(got), 32'd1);
        if (got) check("resp_latency", 32'(cyc - rcyc), 32'(lat + 2));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
    endtask

    task automatic run_tie();
        int order[$];
        int nop[$];
        int rem0, rem1;
        bit done;
        rem0 = 2;
        rem1 = 1;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (arth_newop) nop.push_back(cyc);
            req0_valid = (rem0 > 0); req0_V1 = (rem0 == 2) ? 17'd17 : 17'd100;
            req0_V2 = 17'd13;        req0_opcode = OP1;
            req1_valid = (rem1 > 0); req1_V1 = 17'd17; req1_V2 = 17'd13; req1_opcode = OP1;
            #1;
            if (req0_ready) begin push_exp(0); order.push_back(0); rem0--; end
            if (req1_ready) begin push_exp(1); order.push_back(1); rem1--; end
            @(posedge clock);
            #1;
            done = (rem0 == 0 && rem1 == 0 && sb.size() == 0);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("tie_done", 32'(done), 32'd1);
        check("tie_order_len", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            check("tie_first",  32'(order[0]), 32'd0);
            check("tie_second", 32'(order[1]), 32'd1);
            check("tie_third",  32'(order[2]), 32'd0);
        end
        check("tie_newops", 32'(nop.size()), 32'd3);
        if (nop.size() == 3) begin
            check("newop_gap_a", 32'(nop[1] - nop[0]), 32'd21);
            check("newop_gap_b", 32'(nop[2] - nop[1]), 32'd21);
        end
    endtask

    initial begin
        int rcyc;
        int errs;
        exp_t e;

        reset = 1'b1;
        req0_valid = 1'b1; req0_V1 = 17'd1; req0_V2 = 17'd2; req0_opcode = OP0;
        req1_valid = 1'b1; req1_V1 = 17'd3; req1_V2 = 17'd4; req1_opcode = OP1;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;

        // Reset held 3 cycles with both requests pending.
        repeat (3) begin
            @(posedge clock);
            #1;
            check("rst_ready0", 32'(req0_ready),  32'd0);
            check("rst_ready1", 32'(req1_ready),  32'd0);
            check("rst_newop",  32'(arth_newop),  32'd0);
            check("rst_resp0",  32'(resp0_valid), 32'd0);
            check("rst_resp1",  32'(resp1_valid), 32'd0);
        end
        check("rst_arth_v1",  32'(arth_V1),     32'd0);
        check("rst_arth_op",  32'(arth_opcode), 32'd0);
        check("rst_answer",   32'(resp_answer), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset = 1'b0;
        step(1);

        // Tie from reset: port 0 first, then rotation to port 1, then port 0 again.
        run_tie();

        // Single short op on port 0.
        issue(0, 17'd15, 17'd200, OP0, rcyc);
        wait_resp(0, rcyc, lat_of(OP0));
        step(2);

        // Reset in the middle of a long op on port 1.
        issue(1, 17'd300, 17'd40, OP2, rcyc);
        step(4);
        reset = 1'b1;
        step(1);
        check("midrst_newop",  32'(arth_newop),  32'd0);
        check("midrst_resp1",  32'(resp1_valid), 32'd0);
        check("midrst_v1",     32'(arth_V1),     32'd0);
        check("midrst_answer", 32'(resp_answer), 32'd0);
        sb.delete();
        reset = 1'b0;
        errs = 0;
        repeat (30) begin
            step(1);
            if (arth_newop || resp0_valid || resp1_valid) errs++;
        end
        check("midrst_quiet", 32'(errs), 32'd0);

        // Response back-pressure: result held, other port kept waiting.
        resp0_ready = 1'b0;
        req1_V1 = 17'd9; req1_V2 = 17'd8; req1_opcode = OP3;
        req1_valid = 1'b1;
        issue(0, 17'd1234, 17'd55, OP3, rcyc);
        req1_valid = 1'b1;
        wait_resp(0, rcyc, lat_of(OP3));
        e.ans = f_ans(17'd1234, 17'd55, OP3);
        e.ovw = f_ovw(17'd1234, 17'd55, OP3);
        errs = 0;
        repeat (10) begin
            if (!resp0_valid || resp_answer !== e.ans || resp_ovw !== e.ovw) errs++;
            if (req1_ready || arth_newop) errs++;
            step(1);
        end
        check("hold_stable", 32'(errs), 32'd0);
        resp0_ready = 1'b1;
        step(1);
        wait_accept(1, rcyc);
        wait_resp(1, rcyc, lat_of(OP3));
        step(2);

        // Operand hold while the requester changes its inputs.
        issue(0, 17'd500, 17'd3, OP1, rcyc);
        req0_V1 = 17'h1FFA6;
        errs = 0;
        for (int i = 0; i < 60 && !resp0_valid; i++) begin
            if (arth_V1 !== 17'd500 || arth_V2 !== 17'd3 || arth_opcode !== OP1) errs++;
            step(1);
        end
        check("operand_hold", 32'(errs), 32'd0);
        wait_resp(0, rcyc, lat_of(OP1));
        step(3);
        check("idle_keeps_v1", 32'(arth_V1), 32'd500);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
